cook_timer: RTL and testbench

//   Microwave cook-time countdown: consumes the 1-cycle 1 Hz strobe from the clock divider.

---
 rtl/microwave_pkg.sv | 30 +++
 rtl/cook_timer_if.sv | 32 +++
 rtl/bcd_mmss_dec.sv | 34 +++
 rtl/cook_timer.sv | 137 +++++++++++++
 tb/tb_cook_timer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/microwave_pkg.sv
// Shared types and helpers for the microwave cook-time countdown.
package microwave_pkg;

   // Controller states, 2-bit encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Largest seconds value in packed BCD
   localparam logic [7:0] BCD_MAX_SEC = 8'h59;

   // Alarm counter width: counts 0 .. n-1, never narrower than one bit
   function automatic int alarm_cnt_w(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   // A packed BCD byte is well formed when units <= 9 and tens <= max_tens
   function automatic logic bcd_byte_ok(input logic [7:0] b, input logic [3:0] max_tens);
      return (b[3:0] <= 4'd9) && (b[7:4] <= max_tens);
   endfunction

   // Decimal value of a packed BCD byte
   function automatic int bcd_to_int(input logic [7:0] b);
      return int'(b[7:4]) * 10 + int'(b[3:0]);
   endfunction

endpackage

// File: rtl/cook_timer_if.sv
// Keypad/door inputs and display/magnetron outputs of the cook timer.
interface cook_timer_if;

   logic       tick_1hz;
   logic       load;
   logic [7:0] load_mm;
   logic [7:0] load_ss;
   logic       start;
   logic       pause;
   logic       clear;
   logic       door_open;

   logic [7:0] mm_bcd;
   logic [7:0] ss_bcd;
   logic       running;
   logic       done;
   logic       beep;
   logic       load_err;

   // Controller side: drives the inputs, watches the outputs
   modport master (
      output tick_1hz, load, load_mm, load_ss, start, pause, clear, door_open,
      input  mm_bcd, ss_bcd, running, done, beep, load_err
   );

   // Timer side
   modport slave (
      input  tick_1hz, load, load_mm, load_ss, start, pause, clear, door_open,
      output mm_bcd, ss_bcd, running, done, beep, load_err
   );

endinterface

// File: rtl/bcd_mmss_dec.sv
// Combinational one-second decrement of a packed-BCD MM:SS value.
// At 00:00 the value is passed through unchanged and zero is flagged.
module bcd_mmss_dec
   import microwave_pkg::*;
(
   input  logic [7:0] mm_in,
   input  logic [7:0] ss_in,
   output logic [7:0] mm_out,
   output logic [7:0] ss_out,
   output logic       zero
);

   // Borrow chain: ss units -> ss tens -> mm units -> mm tens
   always_comb begin
      mm_out = mm_in;
      ss_out = ss_in;
      zero   = (mm_in == 8'h00) && (ss_in == 8'h00);
      if (!zero) begin
         if (ss_in[3:0] != 4'd0) begin
            ss_out = {ss_in[7:4], ss_in[3:0] - 4'd1};
         end else if (ss_in[7:4] != 4'd0) begin
            ss_out = {ss_in[7:4] - 4'd1, 4'd9};
         end else begin
            ss_out = BCD_MAX_SEC;
            if (mm_in[3:0] != 4'd0) begin
               mm_out = {mm_in[7:4], mm_in[3:0] - 4'd1};
            end else begin
               mm_out = {mm_in[7:4] - 4'd1, 4'd9};
            end
         end
      end
   end

endmodule

// File: rtl/cook_timer.sv
// Microwave cook-time countdown. Holds MM:SS in BCD, decrements on each
// 1 Hz strobe while running, then beeps for ALARM_SECS strobes.
module cook_timer
   import microwave_pkg::*;
#(
   parameter int MAX_MIN    = 99,
   parameter int ALARM_SECS = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   cook_timer_if.slave   bus
);

   localparam int CNT_W = alarm_cnt_w(ALARM_SECS);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALARM_SECS - 1);

   state_t           state_q, state_n;
   logic [7:0]       mm_q, mm_n;
   logic [7:0]       ss_q, ss_n;
   logic [CNT_W-1:0] cnt_q, cnt_n;
   logic             done_q, done_n;
   logic             err_q, err_n;
   logic             running_q;
   logic             beep_q;

   logic [7:0]       dec_mm;
   logic [7:0]       dec_ss;
   logic             time_zero;
   logic             load_ok;
   logic             start_ok;

   bcd_mmss_dec u_dec (
      .mm_in  (mm_q),
      .ss_in  (ss_q),
      .mm_out (dec_mm),
      .ss_out (dec_ss),
      .zero   (time_zero)
   );

   // Load value is accepted only when it is proper BCD within range
   always_comb begin
      load_ok = bcd_byte_ok(bus.load_mm, 4'd9)
             && bcd_byte_ok(bus.load_ss, BCD_MAX_SEC[7:4])
             && (bcd_to_int(bus.load_mm) <= MAX_MIN);
      start_ok = ((state_q == ST_IDLE) || (state_q == ST_PAUSED))
              && !bus.door_open && !time_zero;
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_n;
   end

   // Next state and next data; an ignored command falls through to lower-priority ones
   always_comb begin
      state_n = state_q;
      mm_n    = mm_q;
      ss_n    = ss_q;
      cnt_n   = cnt_q;
      done_n  = 1'b0;
      err_n   = 1'b0;
      if (bus.clear) begin
         state_n = ST_IDLE;
         mm_n    = 8'h00;
         ss_n    = 8'h00;
         cnt_n   = '0;
      end else if ((bus.door_open || bus.pause) && (state_q == ST_RUN)) begin
         // Any strobe on this edge is discarded
         state_n = ST_PAUSED;
      end else if (bus.start && start_ok) begin
         // A coincident strobe is not counted
         state_n = ST_RUN;
      end else if (bus.load && (state_q != ST_RUN)) begin
         if (load_ok) begin
            mm_n    = bus.load_mm;
            ss_n    = bus.load_ss;
            state_n = ST_IDLE;
            cnt_n   = '0;
         end else begin
            err_n = 1'b1;
         end
      end else if (bus.tick_1hz) begin
         case (state_q)
            ST_RUN: begin
               if (!time_zero) begin
                  mm_n = dec_mm;
                  ss_n = dec_ss;
                  if ((dec_mm == 8'h00) && (dec_ss == 8'h00)) begin
                     state_n = ST_DONE;
                     done_n  = 1'b1;
                     cnt_n   = '0;
                  end
               end
            end
            ST_DONE: begin
               if (cnt_q == CNT_LAST) begin
                  state_n = ST_IDLE;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt_q + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   // Time, alarm counter and registered outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mm_q      <= 8'h00;
         ss_q      <= 8'h00;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
         running_q <= 1'b0;
         beep_q    <= 1'b0;
      end else begin
         mm_q      <= mm_n;
         ss_q      <= ss_n;
         cnt_q     <= cnt_n;
         done_q    <= done_n;
         err_q     <= err_n;
         running_q <= (state_n == ST_RUN);
         beep_q    <= (state_n == ST_DONE);
      end
   end

   assign bus.mm_bcd   = mm_q;
   assign bus.ss_bcd   = ss_q;
   assign bus.running  = running_q;
   assign bus.done     = done_q;
   assign bus.beep     = beep_q;
   assign bus.load_err = err_q;

endmodule

// File: tb/tb_cook_timer.sv
// Directed bench for cook_timer with hand-computed expectations.
module tb_cook_timer;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   cook_timer_if ifc ();

   cook_timer #(.MAX_MIN(99), .ALARM_SECS(3)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
   );

   // 50 MHz clock
   initial clk = 1'b0;
   always #10 clk = ~clk;

   // Advance one edge and sample just after it
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_time(input string tag, input logic [7:0] mm, input logic [7:0] ss);
      chk({tag, ".mm"}, ifc.mm_bcd, mm);
      chk({tag, ".ss"}, ifc.ss_bcd, ss);
   endtask

   task automatic do_load(input logic [7:0] mm, input logic [7:0] ss);
      ifc.load = 1'b1; ifc.load_mm = mm; ifc.load_ss = ss;
      step();
      ifc.load = 1'b0;
   endtask

   task automatic do_start();
      ifc.start = 1'b1; step(); ifc.start = 1'b0;
   endtask

   task automatic do_pause();
      ifc.pause = 1'b1; step(); ifc.pause = 1'b0;
   endtask

   task automatic do_clear();
      ifc.clear = 1'b1; step(); ifc.clear = 1'b0;
   endtask

   task automatic do_tick();
      ifc.tick_1hz = 1'b1; step(); ifc.tick_1hz = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      ifc.tick_1hz = 1'b0; ifc.load = 1'b0; ifc.load_mm = 8'h00; ifc.load_ss = 8'h00;
      ifc.start = 1'b0; ifc.pause = 1'b0; ifc.clear = 1'b0; ifc.door_open = 1'b0;
      step(); step();
      rst_n = 1'b1;

      // Reset state
      chk_time("rst", 8'h00, 8'h00);
      chk("rst.running", {7'd0, ifc.running}, 8'd0);
      chk("rst.beep", {7'd0, ifc.beep}, 8'd0);
      chk("rst.done", {7'd0, ifc.done}, 8'd0);
      chk("rst.err", {7'd0, ifc.load_err}, 8'd0);

      // Reset while running at 01:30
      do_load(8'h01, 8'h30);
      chk_time("ld0130", 8'h01, 8'h30);
      do_start();
      chk("run0130.running", {7'd0, ifc.running}, 8'd1);
      rst_n = 1'b0; step(); rst_n = 1'b1;
      chk_time("rstrun", 8'h00, 8'h00);
      chk("rstrun.running", {7'd0, ifc.running}, 8'd0);
      chk("rstrun.beep", {7'd0, ifc.beep}, 8'd0);

      // 00:02 countdown, done pulse, beep for three strobes
      do_load(8'h00, 8'h02);
      do_start();
      do_tick();
      chk_time("t1", 8'h00, 8'h01);
      chk("t1.done", {7'd0, ifc.done}, 8'd0);
      do_tick();
      chk_time("t2", 8'h00, 8'h00);
      chk("t2.done", {7'd0, ifc.done}, 8'd1);
      chk("t2.beep", {7'd0, ifc.beep}, 8'd1);
      chk("t2.running", {7'd0, ifc.running}, 8'd0);
      step();
      chk("t2+1.done", {7'd0, ifc.done}, 8'd0);
      chk("t2+1.beep", {7'd0, ifc.beep}, 8'd1);
      do_tick();
      do_tick();
      chk("alarm2.beep", {7'd0, ifc.beep}, 8'd1);
      do_tick();
      chk("alarm3.beep", {7'd0, ifc.beep}, 8'd0);
      do_start();
      chk("start0.running", {7'd0, ifc.running}, 8'd0);

      // Borrow chains
      do_load(8'h01, 8'h00);
      do_start();
      do_tick();
      chk_time("b0100", 8'h00, 8'h59);
      do_pause();
      chk("pause.running", {7'd0, ifc.running}, 8'd0);
      do_load(8'h10, 8'h00);
      chk_time("ld1000", 8'h10, 8'h00);
      do_start();
      do_tick();
      chk_time("b1000", 8'h09, 8'h59);

      // Door open with coincident strobe
      do_clear();
      chk_time("clr", 8'h00, 8'h00);
      do_load(8'h00, 8'h45);
      do_start();
      ifc.door_open = 1'b1; ifc.tick_1hz = 1'b1;
      step();
      ifc.tick_1hz = 1'b0;
      chk_time("door", 8'h00, 8'h45);
      chk("door.running", {7'd0, ifc.running}, 8'd0);
      do_start();
      chk("doorstart.running", {7'd0, ifc.running}, 8'd0);
      ifc.door_open = 1'b0;
      do_start();
      chk("resume.running", {7'd0, ifc.running}, 8'd1);
      do_tick();
      chk_time("resume", 8'h00, 8'h44);

      // Load in RUN ignored, invalid loads rejected
      do_load(8'h05, 8'h00);
      chk_time("ldrun", 8'h00, 8'h44);
      chk("ldrun.err", {7'd0, ifc.load_err}, 8'd0);
      do_pause();
      do_load(8'h00, 8'h60);
      chk("ld60.err", {7'd0, ifc.load_err}, 8'd1);
      chk_time("ld60", 8'h00, 8'h44);
      step();
      chk("ld60+1.err", {7'd0, ifc.load_err}, 8'd0);
      do_load(8'h00, 8'h1A);
      chk("ld1a.err", {7'd0, ifc.load_err}, 8'd1);
      chk_time("ld1a", 8'h00, 8'h44);
      do_load(8'h9A, 8'h00);
      chk("ld9a.err", {7'd0, ifc.load_err}, 8'd1);
      do_load(8'h99, 8'h59);
      chk_time("ld9959", 8'h99, 8'h59);
      chk("ld9959.err", {7'd0, ifc.load_err}, 8'd0);
      do_clear();
      do_start();
      chk("clrstart.running", {7'd0, ifc.running}, 8'd0);

      // Clear during beep
      do_load(8'h00, 8'h01);
      do_start();
      do_tick();
      chk("cd.beep", {7'd0, ifc.beep}, 8'd1);
      do_clear();
      chk("cdclr.beep", {7'd0, ifc.beep}, 8'd0);
      chk_time("cdclr", 8'h00, 8'h00);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
